// File: rtl/vector_datapath.sv
// vector_datapath: 4x512-bit vector register file, lane-wise add/multiply ALU
// and 512x512-bit data memory, each behind its own port group.
module vector_datapath #(
    parameter int VLEN      = 512,
    parameter int LANE_W    = 32,
    parameter int MEM_DEPTH = 512,
    parameter int ADDR_W    = 9,
    parameter int NREGS     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_add,
    input  logic              alu_mul,
    input  logic [VLEN-1:0]   alu_a1,
    input  logic [VLEN-1:0]   alu_a2,
    output logic [VLEN-1:0]   alu_a3,
    output logic [VLEN-1:0]   alu_a4,
    input  logic              mem_we,
    input  logic              mem_re,
    input  logic [ADDR_W-1:0] mem_raddr,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [VLEN-1:0]   mem_wdata,
    output logic [VLEN-1:0]   mem_rdata,
    input  logic              rf_random_set,
    input  logic              rf_load,
    input  logic [1:0]        rf_load_addr,
    input  logic [VLEN-1:0]   rf_load_data,
    input  logic              rf_write_enable,
    input  logic [VLEN-1:0]   rf_a3,
    input  logic [VLEN-1:0]   rf_a4,
    input  logic              rf_read,
    output logic [VLEN-1:0]   rf_a1,
    output logic [VLEN-1:0]   rf_a2,
    input  logic              rf_store,
    input  logic [1:0]        rf_store_addr,
    output logic [VLEN-1:0]   rf_store_data
);
    localparam int LANES = VLEN / LANE_W;

    logic [VLEN-1:0] add_lo, add_hi, mul_lo, mul_hi;
    logic [VLEN-1:0] seed [NREGS];
    logic [VLEN-1:0] regs [NREGS];
    logic [VLEN-1:0] mem  [MEM_DEPTH];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0]   a, b;
        logic [LANE_W:0]     s;
        logic [2*LANE_W-1:0] p;
        assign a = alu_a1[i*LANE_W +: LANE_W];
        assign b = alu_a2[i*LANE_W +: LANE_W];
        assign s = {1'b0, a} + {1'b0, b};
        assign p = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
        assign add_lo[i*LANE_W +: LANE_W] = s[LANE_W-1:0];
        assign add_hi[i*LANE_W +: LANE_W] = {{(LANE_W-1){1'b0}}, s[LANE_W]};
        assign mul_lo[i*LANE_W +: LANE_W] = p[LANE_W-1:0];
        assign mul_hi[i*LANE_W +: LANE_W] = p[2*LANE_W-1:LANE_W];
    end

    // Seed pattern: lane i of register k holds k*LANES + i + 1.
    for (genvar k = 0; k < NREGS; k++) begin : g_seed
        for (genvar i = 0; i < LANES; i++) begin : g_sl
            assign seed[k][i*LANE_W +: LANE_W] = LANE_W'(k * LANES + i + 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a3 <= '0;
            alu_a4 <= '0;
        end else if (alu_mul) begin
            alu_a3 <= mul_lo;
            alu_a4 <= mul_hi;
        end else if (alu_add) begin
            alu_a3 <= add_lo;
            alu_a4 <= add_hi;
        end
    end

    // Non-blocking read and write in the same block give read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < MEM_DEPTH; j++) mem[j] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_re) mem_rdata <= mem[mem_raddr];
            if (mem_we) mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
            rf_a1         <= '0;
            rf_a2         <= '0;
            rf_store_data <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (rf_random_set) regs[k] <= seed[k];
                else if (rf_load && rf_load_addr == 2'(k)) regs[k] <= rf_load_data;
                else if (rf_write_enable && k == 2) regs[k] <= rf_a3;
                else if (rf_write_enable && k == 3) regs[k] <= rf_a4;
            end
            if (rf_read) begin
                rf_a1 <= regs[0];
                rf_a2 <= regs[1];
            end
            if (rf_store) rf_store_data <= regs[rf_store_addr];
        end
    end
endmodule

// File: tb/tb_vector_datapath.sv
// tb_vector_datapath: directed scoreboard bench; expectations are queued when
// stimulus is driven and compared one cycle later.
module tb_vector_datapath;
    typedef struct {
        string        tag;
        int           id;
        logic [511:0] val;
    } exp_t;

    localparam int A3 = 0, A4 = 1, RD = 2, RA1 = 3, RA2 = 4, RST = 5;

    logic         clk = 1'b0, reset = 1'b0;
    logic         alu_add = 0, alu_mul = 0, mem_we = 0, mem_re = 0;
    logic         rf_random_set = 0, rf_load = 0, rf_write_enable = 0, rf_read = 0, rf_store = 0;
    logic [8:0]   mem_raddr = 0, mem_waddr = 0;
    logic [1:0]   rf_load_addr = 0, rf_store_addr = 0;
    logic [511:0] alu_a1 = 0, alu_a2 = 0, mem_wdata = 0, rf_load_data = 0, rf_a3 = 0, rf_a4 = 0;
    logic [511:0] alu_a3, alu_a4, mem_rdata, rf_a1, rf_a2, rf_store_data;
    exp_t q[$];
    int compared = 0, mismatched = 0;

    vector_datapath dut (
        .clk(clk), .reset(reset),
        .alu_add(alu_add), .alu_mul(alu_mul), .alu_a1(alu_a1), .alu_a2(alu_a2),
        .alu_a3(alu_a3), .alu_a4(alu_a4),
        .mem_we(mem_we), .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rf_random_set(rf_random_set), .rf_load(rf_load), .rf_load_addr(rf_load_addr),
        .rf_load_data(rf_load_data), .rf_write_enable(rf_write_enable),
        .rf_a3(rf_a3), .rf_a4(rf_a4), .rf_read(rf_read), .rf_a1(rf_a1), .rf_a2(rf_a2),
        .rf_store(rf_store), .rf_store_addr(rf_store_addr), .rf_store_data(rf_store_data)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] rep(input logic [31:0] x);
        return {16{x}};
    endfunction

    function automatic logic [511:0] seed(input int k);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(k * 16 + i + 1);
        return v;
    endfunction

    function automatic logic [511:0] rnd();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [511:0] obs(input int id);
        case (id)
            A3:      return alu_a3;
            A4:      return alu_a4;
            RD:      return mem_rdata;
            RA1:     return rf_a1;
            RA2:     return rf_a2;
            default: return rf_store_data;
        endcase
    endfunction

    task automatic check(input string tag, input logic [511:0] o, input logic [511:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic expect_out(input string tag, input int id, input logic [511:0] v);
        exp_t e;
        e.tag = tag; e.id = id; e.val = v;
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            check(e.tag, obs(e.id), e.val);
        end
    endtask

    task automatic idle();
        {alu_add, alu_mul, mem_we, mem_re, rf_random_set, rf_load, rf_write_enable, rf_read, rf_store} = '0;
    endtask

    initial begin
        logic [511:0] a, b, lo, hi;
        logic [32:0]  s;
        logic [63:0]  p;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        // Make every output nonzero, then drop reset mid-cycle.
        alu_a1 = rnd(); alu_a2 = rnd(); alu_add = 1;
        mem_we = 1; mem_waddr = 9'd5; mem_wdata = rnd();
        rf_random_set = 1;
        step();
        idle(); rf_read = 1; rf_store = 1; rf_store_addr = 2'd3; mem_re = 1; mem_raddr = 9'd5; alu_mul = 1;
        step();
        #2;
        alu_a1 = rnd(); mem_wdata = rnd(); rf_load_data = rnd();
        reset = 1'b0;
        #1;
        check("rst_alu_a3", alu_a3, '0);
        check("rst_alu_a4", alu_a4, '0);
        check("rst_mem_rdata", mem_rdata, '0);
        check("rst_rf_a1", rf_a1, '0);
        check("rst_rf_a2", rf_a2, '0);
        check("rst_rf_store", rf_store_data, '0);
        @(negedge clk);
        idle(); reset = 1'b1;
        mem_re = 1; mem_raddr = 9'd5; expect_out("mem_addr5_cleared", RD, '0);
        rf_read = 1; expect_out("rf_a1_cleared", RA1, '0); expect_out("rf_a2_cleared", RA2, '0);
        step();

        idle(); alu_a1 = rep(32'hFFFF_FFFF); alu_a2 = rep(32'd2); alu_add = 1;
        expect_out("add_lo", A3, rep(32'd1)); expect_out("add_carry", A4, rep(32'd1));
        step();
        idle(); alu_a1 = rnd();
        expect_out("add_hold_lo", A3, rep(32'd1)); expect_out("add_hold_hi", A4, rep(32'd1));
        step();
        alu_a1 = rep(32'h0001_0000); alu_a2 = rep(32'h0003_0000); alu_add = 1; alu_mul = 1;
        expect_out("mul_prio_lo", A3, '0); expect_out("mul_prio_hi", A4, rep(32'd3));
        step();
        for (int t = 0; t < 4; t++) begin
            a = rnd(); b = rnd();
            for (int i = 0; i < 16; i++) begin
                s = {1'b0, a[i*32 +: 32]} + {1'b0, b[i*32 +: 32]};
                p = {32'd0, a[i*32 +: 32]} * {32'd0, b[i*32 +: 32]};
                lo[i*32 +: 32] = t[0] ? p[31:0] : s[31:0];
                hi[i*32 +: 32] = t[0] ? p[63:32] : {31'd0, s[32]};
            end
            idle(); alu_a1 = a; alu_a2 = b; alu_add = ~t[0]; alu_mul = t[0];
            expect_out(t[0] ? "rand_mul_lo" : "rand_add_lo", A3, lo);
            expect_out(t[0] ? "rand_mul_hi" : "rand_add_hi", A4, hi);
            step();
        end

        idle(); mem_we = 1; mem_waddr = 9'h1FF; mem_wdata = rep(32'hABAB_ABAB);
        step();
        idle(); mem_re = 1; mem_raddr = 9'h1FF; expect_out("mem_rd_1ff", RD, rep(32'hABAB_ABAB));
        step();
        mem_we = 1; mem_waddr = 9'h1FF; mem_wdata = rep(32'h1111_1111);
        expect_out("mem_rbw_old", RD, rep(32'hABAB_ABAB));
        step();
        idle(); mem_re = 1; expect_out("mem_rd_new", RD, rep(32'h1111_1111));
        step();
        idle(); mem_raddr = 9'd0; expect_out("mem_hold", RD, rep(32'h1111_1111));
        step();

        idle(); rf_random_set = 1;
        step();
        idle(); rf_read = 1; rf_store = 1; rf_store_addr = 2'd3;
        expect_out("seed_r0", RA1, seed(0)); expect_out("seed_r1", RA2, seed(1));
        expect_out("seed_r3", RST, seed(3));
        step();
        idle(); rf_load = 1; rf_load_addr = 2'd1; rf_load_data = '1;
        rf_write_enable = 1; rf_a3 = rep(32'd5); rf_a4 = rep(32'd7);
        rf_read = 1; expect_out("no_bypass_r1", RA2, seed(1));
        step();
        idle(); rf_read = 1; rf_store = 1; rf_store_addr = 2'd2;
        expect_out("load_r0_kept", RA1, seed(0)); expect_out("load_r1", RA2, '1);
        expect_out("we_r2", RST, rep(32'd5));
        step();
        idle(); rf_store = 1; rf_store_addr = 2'd3; expect_out("we_r3", RST, rep(32'd7));
        step();
        idle(); rf_load = 1; rf_load_addr = 2'd2; rf_load_data = rep(32'h1234_5678);
        rf_write_enable = 1; rf_a3 = rep(32'd9); rf_a4 = rep(32'd8);
        step();
        idle(); rf_store = 1; rf_store_addr = 2'd2; expect_out("load_beats_we_r2", RST, rep(32'h1234_5678));
        step();
        idle(); rf_store = 1; rf_store_addr = 2'd3; expect_out("we_r3_with_load", RST, rep(32'd8));
        step();
        idle(); rf_random_set = 1; rf_load = 1; rf_load_addr = 2'd0; rf_load_data = '0;
        rf_write_enable = 1;
        step();
        idle(); rf_read = 1; rf_store = 1; rf_store_addr = 2'd2;
        expect_out("prio_seed_r0", RA1, seed(0)); expect_out("prio_seed_r2", RST, seed(2));
        step();
        idle(); rf_store_addr = 2'd1;
        expect_out("rf_hold_a1", RA1, seed(0)); expect_out("rf_hold_store", RST, seed(2));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
